// File: rtl/serial_mag_comparator.sv
// Multi-cycle magnitude comparator: walks WIDTH-bit operands MSB-first, CHUNK bits per
// clock, with optional early finish at the first differing chunk and signed/unsigned modes.
module serial_mag_comparator #(
   parameter int WIDTH      = 16,
   parameter int CHUNK      = 4,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             lt,
   output logic             gt
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);
   localparam bit EE = (EARLY_EXIT != 0);

   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic             sm_q;
   logic [CW-1:0]    cnt_q;
   logic             dec_q, dec_lt_q;

   logic [CHUNK-1:0] ca, cb;
   logic             accept, in_cmp, last_chunk;
   logic             chunk_diff, chunk_lt;
   logic             fin_eq, fin_lt, fin_gt, finish;

   assign accept     = start && (state_q == IDLE || state_q == DONE);
   assign in_cmp     = (state_q == CMP);
   assign last_chunk = (cnt_q == LAST_CNT);

   // Flipping the sign bit of the leading chunk turns a two's-complement order into unsigned order
   always_comb begin
      ca = a_q[WIDTH-1 -: CHUNK];
      cb = b_q[WIDTH-1 -: CHUNK];
      if (sm_q && cnt_q == '0) begin
         ca[CHUNK-1] = ~ca[CHUNK-1];
         cb[CHUNK-1] = ~cb[CHUNK-1];
      end
   end

   assign chunk_diff = (ca != cb);
   assign chunk_lt   = (ca < cb);

   // A difference already recorded in an earlier chunk wins over anything seen later
   assign fin_lt = dec_q ? dec_lt_q  : (chunk_diff & chunk_lt);
   assign fin_gt = dec_q ? ~dec_lt_q : (chunk_diff & ~chunk_lt);
   assign fin_eq = ~dec_q & ~chunk_diff;
   assign finish = in_cmp && ((EE && chunk_diff) || last_chunk);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CMP;
         CMP:     if (finish) state_d = DONE;
         DONE:    state_d = start ? CMP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dec_q    <= 1'b0;
         dec_lt_q <= 1'b0;
         eq       <= 1'b0;
         lt       <= 1'b0;
         gt       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q <= '0;
            dec_q <= 1'b0;
         end else if (in_cmp) begin
            cnt_q <= cnt_q + 1'b1;
            if (!dec_q && chunk_diff) begin
               dec_q    <= 1'b1;
               dec_lt_q <= chunk_lt;
            end
         end
         if (finish) begin
            eq <= fin_eq;
            lt <= fin_lt;
            gt <= fin_gt;
         end
      end
   end

   // Operand shift registers carry data only, so they need no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q  <= a;
         b_q  <= b;
         sm_q <= signed_mode;
      end else if (in_cmp) begin
         a_q <= a_q << CHUNK;
         b_q <= b_q << CHUNK;
      end
   end

   assign busy = in_cmp;
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench: two comparators (early exit on / off) share operands; expected verdict
// and latency come from plain signed/unsigned arithmetic and a chunk scan.
module tb_serial_mag_comparator;

   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int NCHUNK = WIDTH / CHUNK;

   typedef struct {
      logic [2:0] res;   // {eq, lt, gt}
      int         lat;
      int         acc;
   } item_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       start = 2'b00;
   logic [WIDTH-1:0] a = '0, b = '0;
   logic             sm = 1'b0;
   logic [1:0]       busy, done, eq, lt, gt;

   int    cyc = 0;
   int    tests = 0;
   int    fails = 0;
   item_t q0[$], q1[$];

   // index 0: EARLY_EXIT=1, index 1: EARLY_EXIT=0
   serial_mag_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1)) dut_ee (
      .clk(clk), .rst(rst), .start(start[0]), .a(a), .b(b), .signed_mode(sm),
      .busy(busy[0]), .done(done[0]), .eq(eq[0]), .lt(lt[0]), .gt(gt[0]));

   serial_mag_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(0)) dut_full (
      .clk(clk), .rst(rst), .start(start[1]), .a(a), .b(b), .signed_mode(sm),
      .busy(busy[1]), .done(done[1]), .eq(eq[1]), .lt(lt[1]), .gt(gt[1]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [2:0] model(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic s);
      logic l, g;
      if (s) begin
         l = $signed(x) < $signed(y);
         g = $signed(x) > $signed(y);
      end else begin
         l = x < y;
         g = x > y;
      end
      return {x == y, l, g};
   endfunction

   function automatic int lat_early(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y);
      for (int i = 0; i < NCHUNK; i++)
         if (x[WIDTH-1-i*CHUNK -: CHUNK] != y[WIDTH-1-i*CHUNK -: CHUNK]) return i + 1;
      return NCHUNK;
   endfunction

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(int d, logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic s, int acc);
      item_t it;
      it.res = model(x, y, s);
      it.lat = (d == 0) ? lat_early(x, y) : NCHUNK;
      it.acc = acc;
      if (d == 0) q0.push_back(it);
      else        q1.push_back(it);
   endtask

   task automatic issue(logic [1:0] mask, logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic s);
      @(negedge clk);
      a = x; b = y; sm = s; start = mask;
      for (int d = 0; d < 2; d++) if (mask[d]) push(d, x, y, s, cyc + 1);
      @(negedge clk);
      start = 2'b00;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (busy == 2'b00 && done == 2'b00 && q0.size() == 0 && q1.size() == 0) ok = 1;
      end
      if (!ok) chk("wait_idle_timeout", 0, 1);
   endtask

   task automatic monitor();
      item_t it;
      logic [2:0] got;
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int d = 0; d < 2; d++) begin
               if (busy[d] && done[d]) chk("busy_and_done", 1, 0);
               if (done[d]) begin
                  got = {eq[d], lt[d], gt[d]};
                  if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                     chk("unexpected_done", d, -1);
                  end else begin
                     it = (d == 0) ? q0.pop_front() : q1.pop_front();
                     chk(d == 0 ? "result_ee" : "result_full", int'(got), int'(it.res));
                     chk(d == 0 ? "latency_ee" : "latency_full", cyc - it.acc, it.lat);
                  end
               end
            end
         end
      end
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      bit got_done;

      repeat (2) @(negedge clk);
      chk("reset_outputs", int'({busy, done, eq, lt, gt}), 0);
      rst = 1'b0;
      fork
         monitor();
      join_none

      // equal operands
      issue(2'b11, 16'hABCD, 16'hABCD, 1'b0);
      chk("busy_after_accept", int'(busy), 3);
      wait_idle();

      // leading-chunk difference
      issue(2'b11, 16'h1234, 16'h2234, 1'b0);
      wait_idle();

      // signed vs unsigned on the same bits
      issue(2'b11, 16'h8000, 16'h0001, 1'b1);
      wait_idle();
      issue(2'b11, 16'h8000, 16'h0001, 1'b0);
      wait_idle();

      // last-chunk difference, then results held through idle cycles
      issue(2'b11, 16'h0005, 16'h0004, 1'b0);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("hold_ee",   int'({eq[0], lt[0], gt[0]}), 1);
      chk("hold_full", int'({eq[1], lt[1], gt[1]}), 1);

      // start pulsed during CMP with different operands is ignored
      issue(2'b10, 16'h0003, 16'h0007, 1'b0);
      a = 16'h0000; b = 16'hFFFF; sm = 1'b1; start = 2'b10;
      @(negedge clk);
      start = 2'b00;
      wait_idle();

      // back-to-back: start held high through DONE
      @(negedge clk);
      a = 16'h1234; b = 16'h1235; sm = 1'b0; start = 2'b10;
      push(1, a, b, sm, cyc + 1);
      got_done = 0;
      for (int i = 0; i < 20 && !got_done; i++) begin
         @(negedge clk);
         if (done[1]) got_done = 1;
      end
      if (!got_done) chk("b2b_timeout", 0, 1);
      a = 16'h8000; b = 16'h0001; sm = 1'b1;
      push(1, a, b, sm, cyc + 1);
      @(negedge clk);
      start = 2'b00;
      chk("b2b_busy", int'(busy[1]), 1);
      chk("b2b_no_done", int'(done[1]), 0);
      wait_idle();

      // asynchronous reset two cycles into a compare
      issue(2'b11, 16'h0005, 16'h0004, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("midop_reset_outputs", int'({busy, done, eq, lt, gt}), 0);
      q0.delete();
      q1.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      issue(2'b11, 16'h4321, 16'h4320, 1'b1);
      wait_idle();

      // randomized operands, biased toward shared prefixes
      for (int n = 0; n < 40; n++) begin
         ra = WIDTH'($urandom);
         case ($urandom_range(0, 2))
            0: rb = WIDTH'($urandom);
            1: rb = ra;
            default: rb = ra ^ WIDTH'($urandom_range(1, 15) << (CHUNK * $urandom_range(0, NCHUNK - 1)));
         endcase
         issue(2'b11, ra, rb, 1'($urandom_range(0, 1)));
         wait_idle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
